// File: rtl/turn_sequencer.sv
// Tic-tac-toe turn sequencer: debounced buttons, move validation, commit strobe and game state.
// Optional turn timeout is built in when the TURN_TIMEOUT_EN macro is defined.
module turn_sequencer #(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned DB_W      = 16,
  parameter int unsigned TO_CYCLES = 1000,
  parameter int unsigned TO_W      = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       buttonX,
  input  logic       buttonO,
  input  logic [8:0] sel_pos,
  input  logic [8:0] occ_square,
  input  logic [1:0] result,
  output logic       commit,
  output logic       commit_player,
  output logic [8:0] commit_pos,
  output logic       turnX,
  output logic       turnO,
  output logic [7:0] game_st
);

  typedef enum logic [3:0] {
    StStart, StTurnX, StErrX, StCommitX, StCheckX,
    StTurnO, StErrO, StCommitO, StCheckO, StWinX, StWinO, StCats
  } state_e;

  localparam logic [DB_W-1:0] DbLast = DB_W'(DB_CYCLES - 1);

  // Index 0 carries the X button, index 1 the O button.
  logic [1:0]            sync1_q, sync2_q, db_q, db_d, press;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  state_e                state_q, state_d;
  logic [8:0]            pos_q, pos_d;
  logic                  press_x, press_o, move_valid, in_x_wait, in_o_wait, timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_cnt_q <= '0;
      state_q  <= StStart;
      pos_q    <= '0;
    end else begin
      sync1_q  <= {buttonO, buttonX};
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      pos_q    <= pos_d;
    end
  end

  // A level is accepted once it has differed from the debounced value for DB_CYCLES samples.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    press    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbLast) begin
        db_d[i]     = sync2_q[i];
        db_cnt_d[i] = '0;
        press[i]    = sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  assign press_x    = press[0];
  assign press_o    = press[1];
  assign move_valid = (sel_pos != '0) && ((sel_pos & (sel_pos - 9'd1)) == '0) &&
                      ((sel_pos & occ_square) == '0);
  assign in_x_wait  = state_q inside {StTurnX, StErrX};
  assign in_o_wait  = state_q inside {StTurnO, StErrO};

`ifdef TURN_TIMEOUT_EN
  localparam logic [TO_W-1:0] ToLast = TO_W'(TO_CYCLES - 1);

  logic [TO_W-1:0] to_q, to_d;

  // Restarts on every entry to a turn and keeps running through the error state.
  assign to_d    = (in_x_wait || in_o_wait) ? to_q + TO_W'(1) : '0;
  assign timeout = (in_x_wait || in_o_wait) && (to_q == ToLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  logic unused_to_params;
  assign unused_to_params = ^{TO_CYCLES, TO_W};
  assign timeout          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    unique case (state_q)
      StStart: state_d = StTurnX;
      StTurnX, StErrX: begin
        if (press_x && !press_o && move_valid) begin
          state_d = StCommitX;
          pos_d   = sel_pos;
        end else if (press_x || press_o) begin
          state_d = StErrX;
        end
      end
      StCommitX: state_d = StCheckX;
      StCheckX: begin
        case (result)
          2'd3:    state_d = StWinX;
          2'd1:    state_d = StCats;
          2'd0:    state_d = StTurnO;
          default: state_d = StCheckX;
        endcase
      end
      StTurnO, StErrO: begin
        if (press_o && !press_x && move_valid) begin
          state_d = StCommitO;
          pos_d   = sel_pos;
        end else if (press_x || press_o) begin
          state_d = StErrO;
        end
      end
      StCommitO: state_d = StCheckO;
      StCheckO: begin
        case (result)
          2'd2:    state_d = StWinO;
          2'd1:    state_d = StCats;
          2'd0:    state_d = StTurnX;
          default: state_d = StCheckO;
        endcase
      end
      StWinX, StWinO, StCats: state_d = state_q;
      default: state_d = StStart;
    endcase
    if (timeout) begin
      state_d = in_x_wait ? StWinO : StWinX;
    end
  end

  always_comb begin
    commit        = state_q inside {StCommitX, StCommitO};
    commit_player = (state_q == StCommitX);
    commit_pos    = commit ? pos_q : '0;
    turnX         = in_x_wait;
    turnO         = in_o_wait;
    game_st       = 8'h00;
    case (state_q)
      StErrX, StErrO: game_st = 8'h45;
      StWinX:         game_st = 8'h58;
      StWinO:         game_st = 8'h4F;
      StCats:         game_st = 8'h43;
      default:        game_st = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: scripted vector table, hand-written corner cases and random games
// checked against a board-level game model.
module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       buttonX = 1'b0;
  logic       buttonO = 1'b0;
  logic [8:0] sel_pos = '0;
  logic [8:0] occ_square;
  logic [1:0] result;
  logic       commit, commit_player, turnX, turnO;
  logic [8:0] commit_pos;
  logic [7:0] game_st;

  int checks = 0;
  int errors = 0;

  // Game model: board contents, whose move, error flag, end-of-game.
  logic [8:0] bx = '0, bo = '0;
  logic       m_turn_x = 1'b1, m_err = 1'b0, m_over = 1'b0;
  logic [7:0] m_gst = 8'h00;

  turn_sequencer #(
    .DB_CYCLES(4),
    .DB_W     (3),
    .TO_CYCLES(20),
    .TO_W     (5)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .buttonX      (buttonX),
    .buttonO      (buttonO),
    .sel_pos      (sel_pos),
    .occ_square   (occ_square),
    .result       (result),
    .commit       (commit),
    .commit_player(commit_player),
    .commit_pos   (commit_pos),
    .turnX        (turnX),
    .turnO        (turnO),
    .game_st      (game_st)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] result_of(input logic [8:0] x, input logic [8:0] o);
    logic [8:0] ln [8];
    ln = '{9'h1C0, 9'h038, 9'h007, 9'h124, 9'h092, 9'h049, 9'h111, 9'h054};
    for (int k = 0; k < 8; k++) if ((x & ln[k]) == ln[k]) return 2'd3;
    for (int k = 0; k < 8; k++) if ((o & ln[k]) == ln[k]) return 2'd2;
    if ((x | o) == 9'h1FF) return 2'd1;
    return 2'd0;
  endfunction

  assign occ_square = bx | bo;
  assign result     = result_of(bx, bo);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    buttonX = 1'b0;
    buttonO = 1'b0;
    sel_pos = '0;
    bx = '0;
    bo = '0;
    m_turn_x = 1'b1;
    m_err = 1'b0;
    m_over = 1'b0;
    m_gst = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_commit", commit, 0);
    chk("rst_commit_pos", commit_pos, 0);
    chk("rst_turns", {turnX, turnO}, 2'b00);
    chk("rst_game_st", game_st, 8'h00);
    reset_n = 1'b1;
    #1;
    chk("start_turns", {turnX, turnO}, 2'b00);
    @(negedge clk);
    chk("first_turn_x", {turnX, turnO}, 2'b10);
    chk("first_game_st", game_st, 8'h00);
    chk("first_commit", commit, 0);
  endtask

  // Press for 8 cycles, release for 8; observe commits and post-move state.
  task automatic press(input string tag, input logic px, input logic po, input logic [8:0] pos,
                       input logic e_commit, input logic [7:0] e_gst,
                       input logic e_tx, input logic e_to);
    int         ci, nc;
    logic [8:0] cp;
    logic       cpl, prev;
    ci = -100;
    nc = 0;
    cp = '0;
    cpl = 1'b0;
    prev = 1'b0;
    sel_pos = pos;
    buttonX = px;
    buttonO = po;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 8) begin
        buttonX = 1'b0;
        buttonO = 1'b0;
      end
      if (commit) begin
        chk({tag, "_commit_gap"}, prev, 0);
        if (nc == 0) begin
          ci = i;
          cp = commit_pos;
          cpl = commit_player;
          if (e_commit) begin
            if (px) bx = bx | pos;
            else bo = bo | pos;
          end
        end
        nc++;
      end
      if (i == ci + 1) chk({tag, "_check_turns"}, {turnX, turnO}, 2'b00);
      if (i == ci + 2) chk({tag, "_latency_turns"}, {turnX, turnO}, {e_tx, e_to});
      prev = commit;
    end
    chk({tag, "_commit_count"}, nc, {31'd0, e_commit});
    if (e_commit) begin
      chk({tag, "_commit_pos"}, cp, pos);
      chk({tag, "_commit_player"}, cpl, px);
    end
    chk({tag, "_game_st"}, game_st, e_gst);
    chk({tag, "_turns"}, {turnX, turnO}, {e_tx, e_to});
  endtask

  task automatic mpress(input string tag, input logic px, input logic po, input logic [8:0] pos);
    logic       ec, own, oth;
    logic [8:0] nx, no;
    ec = 1'b0;
    nx = bx;
    no = bo;
    if (!m_over) begin
      own = m_turn_x ? px : po;
      oth = m_turn_x ? po : px;
      if (own && !oth && $countones(pos) == 1 && (pos & (bx | bo)) == '0) begin
        ec = 1'b1;
        m_err = 1'b0;
        if (m_turn_x) nx = nx | pos;
        else no = no | pos;
        case (result_of(nx, no))
          2'd3: begin m_over = 1'b1; m_gst = 8'h58; end
          2'd2: begin m_over = 1'b1; m_gst = 8'h4F; end
          2'd1: begin m_over = 1'b1; m_gst = 8'h43; end
          default: m_turn_x = !m_turn_x;
        endcase
      end else begin
        m_err = 1'b1;
      end
    end
    press(tag, px, po, pos, ec, m_over ? m_gst : (m_err ? 8'h45 : 8'h00),
          !m_over && m_turn_x, !m_over && !m_turn_x);
  endtask

  typedef struct {
    logic [1:0] btn;  // {X, O}
    logic [8:0] pos;
    logic       exp_commit;
    logic [7:0] exp_gst;
    logic       exp_tx;
    logic       exp_to;
  } vec_t;

  vec_t tbl [16];

  initial begin
`ifdef TURN_TIMEOUT_EN
    do_reset();
    repeat (19) @(negedge clk);
    chk("to_idle_before", game_st, 8'h00);
    chk("to_idle_before_turn", turnX, 1);
    @(negedge clk);
    chk("to_idle_win_o", game_st, 8'h4F);
    chk("to_idle_turns", {turnX, turnO}, 2'b00);

    do_reset();
    press("to_err", 1'b0, 1'b1, 9'h010, 1'b0, 8'h45, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("to_err_before", game_st, 8'h45);
    @(negedge clk);
    chk("to_err_win_o", game_st, 8'h4F);

    do_reset();
    press("to_x_move", 1'b1, 1'b0, 9'h010, 1'b1, 8'h00, 1'b0, 1'b1);
    begin
      int n;
      n = 0;
      while (game_st == 8'h00 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("to_o_win_x", game_st, 8'h58);
      chk("to_o_turns", {turnX, turnO}, 2'b00);
    end
`else
    tbl[0]  = '{2'b10, 9'h010, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{2'b11, 9'h001, 1'b0, 8'h45, 1'b0, 1'b1};
    tbl[2]  = '{2'b10, 9'h100, 1'b0, 8'h45, 1'b0, 1'b1};
    tbl[3]  = '{2'b01, 9'h010, 1'b0, 8'h45, 1'b0, 1'b1};
    tbl[4]  = '{2'b01, 9'h003, 1'b0, 8'h45, 1'b0, 1'b1};
    tbl[5]  = '{2'b01, 9'h001, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{2'b01, 9'h002, 1'b0, 8'h45, 1'b1, 1'b0};
    tbl[7]  = '{2'b10, 9'h003, 1'b0, 8'h45, 1'b1, 1'b0};
    tbl[8]  = '{2'b10, 9'h001, 1'b0, 8'h45, 1'b1, 1'b0};
    tbl[9]  = '{2'b10, 9'h100, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[10] = '{2'b01, 9'h020, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{2'b10, 9'h080, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[12] = '{2'b01, 9'h008, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[13] = '{2'b10, 9'h040, 1'b1, 8'h58, 1'b0, 1'b0};
    tbl[14] = '{2'b10, 9'h002, 1'b0, 8'h58, 1'b0, 1'b0};
    tbl[15] = '{2'b01, 9'h004, 1'b0, 8'h58, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      press($sformatf("tbl%0d", i), tbl[i].btn[1], tbl[i].btn[0], tbl[i].pos,
            tbl[i].exp_commit, tbl[i].exp_gst, tbl[i].exp_tx, tbl[i].exp_to);
    end

    // Drawn game: X O X / X O O / O X X
    begin
      int sq [9];
      sq = '{8, 7, 6, 4, 5, 3, 1, 2, 0};
      do_reset();
      for (int i = 0; i < 9; i++) begin
        mpress($sformatf("cats%0d", i), (i % 2) == 0, (i % 2) == 1, 9'(1 << sq[i]));
      end
      chk("cats_game_st", game_st, 8'h43);
      chk("cats_turns", {turnX, turnO}, 2'b00);
    end

    begin
      int nc;
      do_reset();
      nc = 0;
      sel_pos = 9'h010;
      buttonX = 1'b1;
      repeat (2) @(negedge clk);
      buttonX = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (commit) nc++;
      end
      chk("glitch_commits", nc, 0);
      chk("glitch_turns", {turnX, turnO}, 2'b10);
      chk("glitch_game_st", game_st, 8'h00);
    end

    begin
      logic found;
      do_reset();
      found = 1'b0;
      sel_pos = 9'h010;
      buttonX = 1'b1;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk);
        if (commit) found = 1'b1;
      end
      chk("rst_mid_commit_seen", found, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_commit", commit, 0);
      chk("rst_mid_commit_pos", commit_pos, 0);
      chk("rst_mid_turns", {turnX, turnO}, 2'b00);
      buttonX = 1'b0;
    end

    for (int g = 0; g < 6; g++) begin
      do_reset();
      for (int s = 0; s < 16; s++) begin
        logic       px, po;
        logic [8:0] pos, free;
        int         r, k;
        r = $urandom_range(0, 9);
        if (r < 7)       begin px = m_turn_x;  po = !m_turn_x; end
        else if (r == 7) begin px = !m_turn_x; po = m_turn_x;  end
        else             begin px = 1'b1;      po = 1'b1;      end
        free = ~(bx | bo);
        if ($urandom_range(0, 9) < 7 && free != '0) begin
          k = $urandom_range(0, 8);
          while (!free[k]) k = $urandom_range(0, 8);
          pos = 9'(1 << k);
        end else begin
          pos = 9'($urandom);
        end
        mpress($sformatf("rnd%0d_%0d", g, s), px, po, pos);
      end
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
